// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB GPIO arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int APB_ADDR_W      = 4;
    localparam int APB_DATA_W      = 32;
    localparam int DEFAULT_TIMEOUT = 16;

    localparam logic [APB_DATA_W-1:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_gpio_arbiter_rr_pick.sv
// Round-robin pick: first pending requester strictly after last_grant_i, wrapping modulo NREQ.
module rr_pick
    import apb_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid_i,
    input  logic [IDXW-1:0] last_grant_i,
    output logic [NREQ-1:0] grant_oh_o,
    output logic [IDXW-1:0] grant_idx_o
);

    always_comb begin
        int              idx;
        logic [IDXW-1:0] pick;
        logic            found;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        pick        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last_grant_i) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            pick = IDXW'(idx);
            if (!found && req_valid_i[pick]) begin
                found             = 1'b1;
                grant_oh_o[pick]  = 1'b1;
                grant_idx_o       = pick;
            end
        end
    end

endmodule

// File: rtl/apb_gpio_arbiter.sv
// Round-robin APB master sharing one GPIO-class slave among NREQ requesters.
// Optional ACCESS watchdog enabled by defining ARB_TIMEOUT_EN.
module apb_gpio_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic [NREQ-1:0]                  req_valid,
    input  logic [NREQ-1:0]                  req_write,
    input  logic [NREQ-1:0][APB_ADDR_W-1:0]  req_addr,
    input  logic [NREQ-1:0][APB_DATA_W-1:0]  req_wdata,
    output logic [NREQ-1:0]                  req_ready,
    output logic [NREQ-1:0]                  rsp_valid,
    output logic [APB_DATA_W-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic                             PSEL,
    output logic                             PENABLE,
    output logic                             PWRITE,
    output logic [APB_ADDR_W-1:0]            PADDR,
    output logic [APB_DATA_W-1:0]            PWDATA,
    input  logic [APB_DATA_W-1:0]            PRDATA,
    input  logic                             PREADY
);

    localparam int IDXW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
        $error("apb_gpio_arbiter: NREQ must be 2..4");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 31) begin : g_bad_timeout
        $error("apb_gpio_arbiter: TIMEOUT_CYC must fit the 5-bit watchdog (1..31)");
    end

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         last_q, last_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [APB_ADDR_W-1:0]   paddr_q, paddr_d;
    logic [APB_DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NREQ-1:0]         req_ready_q, req_ready_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic [NREQ-1:0]         grant_oh;
    logic [IDXW-1:0]         grant_idx;

`ifdef ARB_TIMEOUT_EN
    localparam logic [4:0] TO_LIMIT = 5'(TIMEOUT_CYC);
    logic [4:0] cnt_q, cnt_d;
    logic       rsp_err_q, rsp_err_d;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req_valid_i  (req_valid),
        .last_grant_i (last_q),
        .grant_oh_o   (grant_oh),
        .grant_idx_o  (grant_idx)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        rsp_err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d     = SETUP;
                    last_d      = grant_idx;
                    pwrite_d    = req_write[grant_idx];
                    paddr_d     = req_addr[grant_idx];
                    pwdata_d    = req_wdata[grant_idx];
                    req_ready_d = grant_oh;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                // last_q doubles as the index of the transfer in flight.
                if (PREADY) begin
                    state_d             = IDLE;
                    psel_d              = 1'b0;
                    penable_d           = 1'b0;
                    rsp_valid_d[last_q] = 1'b1;
                    rsp_rdata_d         = pwrite_q ? '0 : PRDATA;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q + 5'd1 == TO_LIMIT) begin
                    state_d             = IDLE;
                    psel_d              = 1'b0;
                    penable_d           = 1'b0;
                    rsp_valid_d[last_q] = 1'b1;
                    rsp_rdata_d         = ERR_RDATA;
                    rsp_err_d           = 1'b1;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            last_q      <= IDXW'(NREQ - 1);
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_gpio_arbiter.sv
// Scoreboard bench for apb_gpio_arbiter with a registered-PREADY GPIO slave model.
module tb_apb_gpio_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 16;

    logic                  PCLK = 1'b0;
    logic                  PRESET;
    logic [NREQ-1:0]       req_valid, req_write;
    logic [NREQ-1:0][3:0]  req_addr;
    logic [NREQ-1:0][31:0] req_wdata;
    logic [NREQ-1:0]       req_ready, rsp_valid;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;
    logic                  PSEL, PENABLE, PWRITE;
    logic [3:0]            PADDR;
    logic [31:0]           PWDATA, PRDATA;
    logic                  PREADY;

    always #5 PCLK = ~PCLK;

    apb_gpio_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // Slave: read data from a fixed table, PREADY registered, optional extra wait states.
    logic [31:0] rd_tab [16];
    int          stall_req;
    int          wait_cnt;
    bit          hang;
    logic        done_wr;
    logic [3:0]  done_addr;
    logic [31:0] done_wdata;

    assign PRDATA = rd_tab[PADDR];

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PREADY   <= 1'b0;
            wait_cnt <= 0;
        end else begin
            if (PSEL && PENABLE && PREADY) begin
                done_wr    <= PWRITE;
                done_addr  <= PADDR;
                done_wdata <= PWDATA;
            end
            if (PSEL && PENABLE && !PREADY && !hang) begin
                if (wait_cnt >= stall_req) begin
                    PREADY   <= 1'b1;
                    wait_cnt <= 0;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end else begin
                PREADY <= 1'b0;
            end
        end
    end

    typedef struct {
        int          r;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   glog[$];
    int   checks = 0;
    int   errors = 0;
    int   n_rsp = 0;
    int   cyc = 0;
    int   last_lat, last_psel, last_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Monitor: arbitration model, APB stability, response scoreboard.
    initial begin
        logic [NREQ-1:0] snap;
        int              model_last, psel_cnt, en_cnt, grant_cyc, g, r, idx;
        logic [3:0]      s_addr;
        logic [31:0]     s_wd;
        logic            s_wr;
        exp_t            e;
        snap = '0; model_last = NREQ - 1; psel_cnt = 0; en_cnt = 0; grant_cyc = 0;
        s_addr = '0; s_wd = '0; s_wr = 1'b0;
        forever begin
            @(negedge PCLK);
            cyc++;
            if (PRESET) begin
                exp_q.delete();
                glog.delete();
                model_last = NREQ - 1;
                psel_cnt = 0;
                en_cnt = 0;
            end else begin
                if (PSEL && !PENABLE) begin
                    s_addr = PADDR; s_wd = PWDATA; s_wr = PWRITE;
                end
                if (PSEL && PENABLE) begin
                    chk("paddr_stable", 32'(PADDR), 32'(s_addr));
                    chk("pwdata_stable", PWDATA, s_wd);
                    chk("pwrite_stable", 32'(PWRITE), 32'(s_wr));
                end
                if (PSEL) psel_cnt++;
                if (PENABLE) en_cnt++;
                if (req_ready != '0) begin
                    chk("req_ready_onehot", 32'($countones(req_ready)), 1);
                    g = rr_model(snap, model_last);
                    chk("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
                    if (g >= 0) model_last = g;
                    for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);
                    grant_cyc = cyc;
                end
                if (rsp_valid != '0) begin
                    chk("rsp_onehot", 32'($countones(rsp_valid)), 1);
                    r = -1;
                    for (int i = 0; i < NREQ; i++) if (rsp_valid[i] && r < 0) r = i;
                    idx = -1;
                    foreach (exp_q[i]) if (idx < 0 && exp_q[i].r == r) idx = i;
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rsp_unexpected: requester %0d got a response, want none", r);
                    end else begin
                        e = exp_q[idx];
                        exp_q.delete(idx);
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (!e.err) begin
                            chk("apb_addr", 32'(done_addr), 32'(e.addr));
                            chk("apb_write", 32'(done_wr), 32'(e.wr));
                            if (e.wr) chk("apb_wdata", done_wdata, e.wdata);
                        end
                    end
                    last_lat = cyc - grant_cyc;
                    last_psel = psel_cnt;
                    last_en = en_cnt;
                    psel_cnt = 0;
                    en_cnt = 0;
                    n_rsp++;
                end
            end
            snap = req_valid;
        end
    end

    task automatic issue(input int r, input logic wr, input logic [3:0] a, input logic [31:0] wd,
                         input logic err, input int max_wait, input bit withdraw_ok);
        exp_t e;
        bit   got;
        int   idx;
        e.r = r; e.wr = wr; e.addr = a; e.wdata = wd; e.err = err;
        e.rdata = err ? 32'hDEAD_BEEF : (wr ? 32'd0 : rd_tab[a]);
        exp_q.push_back(e);
        req_write[r] = wr; req_addr[r] = a; req_wdata[r] = wd; req_valid[r] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < max_wait && !got; t++) begin
            @(posedge PCLK);
            #1;
            if (req_ready[r]) got = 1'b1;
        end
        req_valid[r] = 1'b0;
        if (!got) begin
            idx = -1;
            for (int i = exp_q.size() - 1; i >= 0 && idx < 0; i--) if (exp_q[i].r == r) idx = i;
            if (idx >= 0) exp_q.delete(idx);
            if (!withdraw_ok) begin
                checks++;
                errors++;
                $display("FAIL grant_wait: requester %0d not accepted in %0d cycles", r, max_wait);
            end
        end
    endtask

    task automatic wait_rsp(input int budget);
        int  start;
        bit  seen;
        start = n_rsp;
        seen = 1'b0;
        for (int t = 0; t < budget && !seen; t++) begin
            @(posedge PCLK);
            #1;
            if (n_rsp != start) seen = 1'b1;
        end
        chk("rsp_arrived", 32'(seen), 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int t = 0; t < budget && exp_q.size() != 0; t++) begin
            @(posedge PCLK);
            #1;
        end
        chk("drain", 32'(exp_q.size()), 0);
    endtask

    task automatic gap_watch(input int n);
        for (int k = 0; k < n; k++) begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge PCLK);
                if (rsp_valid != '0) seen = 1'b1;
            end
            chk("gap_rsp_seen", 32'(seen), 1);
            chk("gap_psel_low", 32'(PSEL), 0);
            @(negedge PCLK);
            chk("b2b_ready", 32'(req_ready != '0), 1);
            chk("b2b_psel_high", 32'(PSEL), 1);
        end
    endtask

    initial begin
        bit seen;
        PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        stall_req = 0; hang = 1'b0;
        for (int i = 0; i < 16; i++) rd_tab[i] = $urandom;
        rd_tab[4] = 32'h0000_00A5;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        PRESET = 1'b0;
        @(posedge PCLK);
        #1;

        // Single read: 3 PSEL cycles, 2 PENABLE cycles, response 3 clocks after the ready pulse.
        issue(0, 1'b0, 4'h4, $urandom, 1'b0, 50, 1'b0);
        wait_rsp(20);
        chk("read_latency", 32'(last_lat), 3);
        chk("read_psel_cycles", 32'(last_psel), 3);
        chk("read_penable_cycles", 32'(last_en), 2);

        issue(1, 1'b1, 4'h0, 32'h0000_00FF, 1'b0, 50, 1'b0);
        wait_rsp(20);
        chk("write_latency", 32'(last_lat), 3);
        chk("write_penable_cycles", 32'(last_en), 2);

        // Contention: alternating grants with a single IDLE cycle between transfers.
        glog.delete();
        fork
            begin
                issue(0, 1'($urandom), 4'($urandom), $urandom, 1'b0, 50, 1'b0);
                issue(0, 1'($urandom), 4'($urandom), $urandom, 1'b0, 50, 1'b0);
            end
            begin
                issue(1, 1'($urandom), 4'($urandom), $urandom, 1'b0, 50, 1'b0);
                issue(1, 1'($urandom), 4'($urandom), $urandom, 1'b0, 50, 1'b0);
            end
            gap_watch(3);
        join
        wait_drain(100);
        chk("contention_count", 32'(glog.size()), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("contention_order", 32'(glog[i]), 32'(i % 2));

        // Reset in the middle of requester 1's ACCESS phase.
        stall_req = 30;
        issue(1, 1'b0, 4'($urandom), $urandom, 1'b0, 50, 1'b0);
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge PCLK);
            if (PENABLE) seen = 1'b1;
        end
        chk("reached_access", 32'(seen), 1);
        PRESET = 1'b1;
        #1;
        chk("abort_psel", 32'(PSEL), 0);
        chk("abort_penable", 32'(PENABLE), 0);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        repeat (2) @(posedge PCLK);
        #1;
        stall_req = 0;
        PRESET = 1'b0;
        fork
            issue(0, 1'b0, 4'($urandom), $urandom, 1'b0, 50, 1'b0);
            issue(1, 1'b1, 4'($urandom), $urandom, 1'b0, 50, 1'b0);
        join
        wait_drain(100);
        chk("post_reset_first", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF_FFFF, 0);

        // Stalled slave: ten wait states, unmapped address passed straight through.
        stall_req = 9;
        issue(0, 1'b0, 4'hC, $urandom, 1'b0, 50, 1'b0);
        wait_rsp(50);
        chk("stall_penable_cycles", 32'(last_en), 11);
        chk("stall_psel_cycles", 32'(last_psel), 12);
        stall_req = 0;

`ifdef ARB_TIMEOUT_EN
        hang = 1'b1;
        issue(0, 1'b0, 4'h8, $urandom, 1'b1, 50, 1'b0);
        wait_rsp(60);
        chk("timeout_access_cycles", 32'(last_en), TO);
        hang = 1'b0;
        glog.delete();
        fork
            issue(0, 1'b0, 4'($urandom), $urandom, 1'b0, 50, 1'b0);
            issue(1, 1'b0, 4'($urandom), $urandom, 1'b0, 50, 1'b0);
        join
        wait_drain(100);
        chk("timeout_next_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF_FFFF, 1);
`endif

        // Random traffic with occasional withdrawals and wait states.
        fork
            for (int k = 0; k < 15; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge PCLK);
                #1;
                stall_req = $urandom_range(0, 2);
                if ($urandom_range(0, 3) == 0)
                    issue(0, 1'($urandom), 4'($urandom), $urandom, 1'b0, $urandom_range(1, 3), 1'b1);
                else
                    issue(0, 1'($urandom), 4'($urandom), $urandom, 1'b0, 100, 1'b0);
            end
            for (int k = 0; k < 15; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge PCLK);
                #1;
                if ($urandom_range(0, 3) == 0)
                    issue(1, 1'($urandom), 4'($urandom), $urandom, 1'b0, $urandom_range(1, 3), 1'b1);
                else
                    issue(1, 1'($urandom), 4'($urandom), $urandom, 1'b0, 100, 1'b0);
            end
        join
        wait_drain(500);
        repeat (5) @(posedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
